keypad_entry_scanner: RTL
=========================

Name: keypad_entry_scanner

Overview:
- Input-side counterpart to the multiplexed seven-segment display driver. The display block drives active-low digit enables and shows units/tens; this block drives active-low keypad columns and reads the rows back.
- Scans a 4x4 matrix keypad, debounces presses, and emits key codes.
- Assembles a two-digit BCD entry (units/tens) used to preset the BCD counter.
- Sits between the board keypad pins and the counter preset logic.

Parameters:
- SCAN_DIV, 100000, clock cycles per column step; must be >= 4.
- DEBOUNCE_SCANS, 4, consecutive identical full-scan results required to accept a press or a release; must be >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- row_in  in  4  keypad rows, active-low (pulled up), asynchronous
- col_drive  out  4  keypad columns, active-low, exactly one bit low
- key_code  out  4  code of last accepted key
- key_valid  out  1  one-cycle pulse when a key is accepted
- key_held  out  1  high while an accepted key has not yet been released
- units  out  4  BCD entry, ones digit
- tens  out  4  BCD entry, tens digit

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous and active-high.
- Reset values: col_drive=4'b1110 (column 0); divider=0; column index=0; scan accumulator cleared; state=IDLE; match and release counters=0; key_code=0; key_valid=0; key_held=0; units=0; tens=0.
- Reset asserted mid-scan or mid-debounce returns all of the above on the next edge. No partial entry survives.
- Row synchroniser: row_in passes through a 2-flop synchroniser before use.
- Tick generation: the divider counts 0..SCAN_DIV-1 and wraps. A tick is the cycle where divider==SCAN_DIV-1.
- Column sampling on each tick:
  - The synchronised rows for the current column are recorded.
  - The column index advances 0->1->2->3->0.
  - col_drive rotates to the next column.
- End-of-scan: the tick that samples column 3. It yields one result:
  - NONE: no row low in any column.
  - SINGLE(code): exactly one row/column intersection low.
  - MULTI: two or more intersections low.
- Key map (row r = row_in bit r, column c = col_drive bit c):
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E(*) 0 F(#) D
- State machine, evaluated only at end-of-scan:
  - IDLE: SINGLE(k) -> stored candidate=k, match count=1, go to CONFIRM. If DEBOUNCE_SCANS==1, accept immediately instead. NONE or MULTI -> stay in IDLE.
  - CONFIRM: SINGLE(candidate) -> increment match count; when it reaches DEBOUNCE_SCANS, accept. Any other result -> back to IDLE, match count=0.
  - HELD: NONE -> increment release count; when it reaches DEBOUNCE_SCANS, go to IDLE and drop key_held. Any other result, including MULTI or a different key -> release count=0, stay in HELD. No second key_valid is produced until release.
- Accept action, all on the same edge:
  - key_code=candidate; key_valid=1 for exactly one cycle; key_held=1; go to HELD.
  - Digit 0-9: tens<=units, units<=digit.
  - Code A: units<=0, tens<=0.
  - Codes B-F: units and tens unchanged.
- key_code holds its value until the next accept.
- key_valid is never high in two consecutive cycles.
- units and tens always hold valid BCD (0-9).

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2; one full scan = 16 cycles):
- Reset then idle 100 cycles -> col_drive cycles 1110,1101,1011,0111, changing every 4 cycles; key_valid never asserts; units=tens=0.
- Hold key "5" (row1 low while col1 driven) for 4 scans, then release -> exactly one key_valid pulse with key_code=5; units=5, tens=0; key_held drops 2 end-of-scans after release.
- Press 7, release, press 3, release -> tens=7, units=3. Then press A -> units=0, tens=0, key_code=A.
- Hold "8" for only 1 end-of-scan, then release -> no key_valid; units/tens unchanged.
- Hold "1" and "2" together for 5 scans -> no key_valid. Releasing "2" while "1" stays held -> accepts 1 after 2 further scans.
- Hold "9" until key_held=1, assert reset for 1 cycle -> next cycle: units=tens=0, key_held=0, col_drive=1110. With "9" still held, it is re-accepted after 2 full scans.

Source files
------------

// File: rtl/keypad_entry_scanner.sv
// keypad_entry_scanner: drives one active-low column of a 4x4 keypad at a time,
// collects the row readback for a full scan, debounces the scan result and
// accepts keys. Accepted digits shift into a two-digit BCD entry.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_IDLE    | no key being tracked; waiting for a single-key scan
//   ST_CONFIRM | candidate key seen; counting identical consecutive scans
//   ST_HELD    | key accepted; counting empty scans before release
module keypad_entry_scanner #(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_drive,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [3:0] units,
  output logic [3:0] tens
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  // A counter at this value means the current scan completes the debounce run.
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_SCANS - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_HELD    = 2'd2
  } state_t;

  logic [3:0]       row_meta_q, row_sync_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [3:0]       col_drive_q;
  logic [15:0]      acc_q, scan_now;
  logic             tick, eos;
  logic [4:0]       hit_cnt;
  logic [3:0]       hit_pos, scan_code;
  logic             scan_none, scan_single, accept;

  state_t           state_q;
  logic [3:0]       cand_q;
  logic [CNT_W-1:0] match_q, rel_q;
  logic [3:0]       key_code_q, units_q, tens_q;
  logic             key_valid_q, key_held_q;

  // Matrix position {row, col} to key code.
  function automatic logic [3:0] key_map(input logic [3:0] pos);
    logic [3:0] code;
    unique case (pos)
      4'd0:  code = 4'h1;
      4'd1:  code = 4'h2;
      4'd2:  code = 4'h3;
      4'd3:  code = 4'hA;
      4'd4:  code = 4'h4;
      4'd5:  code = 4'h5;
      4'd6:  code = 4'h6;
      4'd7:  code = 4'hB;
      4'd8:  code = 4'h7;
      4'd9:  code = 4'h8;
      4'd10: code = 4'h9;
      4'd11: code = 4'hC;
      4'd12: code = 4'hE;
      4'd13: code = 4'h0;
      4'd14: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Two-flop synchroniser for the asynchronous, pulled-up row lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= row_in;
      row_sync_q <= row_meta_q;
    end
  end

  assign tick      = (div_q == DIV_LAST);
  assign eos       = tick && (col_idx_q == 2'd3);
  assign div_d     = tick ? '0 : div_q + 1'b1;
  assign col_idx_d = tick ? col_idx_q + 2'd1 : col_idx_q;

  // Scan result so far with the current column's rows merged in (pressed = 1).
  always_comb begin
    scan_now = acc_q;
    for (int r = 0; r < 4; r++) begin
      scan_now[{2'(r), col_idx_q}] = ~row_sync_q[r];
    end
  end

  // Count pressed intersections; position is only meaningful for a single hit.
  always_comb begin
    hit_cnt = '0;
    hit_pos = '0;
    for (int i = 0; i < 16; i++) begin
      if (scan_now[i]) begin
        hit_cnt = hit_cnt + 5'd1;
        hit_pos = 4'(i);
      end
    end
  end

  assign scan_none   = (hit_cnt == 5'd0);
  assign scan_single = (hit_cnt == 5'd1);
  assign scan_code   = key_map(hit_pos);

  // Column stepping: divider, column index, column drive and scan accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q       <= '0;
      col_idx_q   <= '0;
      col_drive_q <= 4'b1110;
      acc_q       <= '0;
    end else begin
      div_q     <= div_d;
      col_idx_q <= col_idx_d;
      if (tick) begin
        col_drive_q <= {col_drive_q[2:0], col_drive_q[3]};
        acc_q       <= eos ? '0 : scan_now;
      end
    end
  end

  // Accept happens either straight from IDLE (single-scan debounce) or when the
  // confirm run reaches its final matching scan.
  always_comb begin
    accept = 1'b0;
    if (eos && scan_single) begin
      if (state_q == ST_IDLE) begin
        accept = (DEBOUNCE_SCANS == 1);
      end else if (state_q == ST_CONFIRM) begin
        accept = (scan_code == cand_q) && (match_q == DB_LAST);
      end
    end
  end

  // Debounce FSM plus key/entry output registers, advanced at end-of-scan.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cand_q      <= '0;
      match_q     <= '0;
      rel_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      units_q     <= '0;
      tens_q      <= '0;
    end else begin
      key_valid_q <= 1'b0;
      if (accept) begin
        state_q     <= ST_HELD;
        cand_q      <= scan_code;
        match_q     <= '0;
        rel_q       <= '0;
        key_code_q  <= scan_code;
        key_valid_q <= 1'b1;
        key_held_q  <= 1'b1;
        if (scan_code <= 4'd9) begin
          tens_q  <= units_q;
          units_q <= scan_code;
        end else if (scan_code == 4'hA) begin
          tens_q  <= '0;
          units_q <= '0;
        end
      end else if (eos) begin
        unique case (state_q)
          ST_IDLE: begin
            if (scan_single) begin
              cand_q  <= scan_code;
              match_q <= CNT_W'(1);
              state_q <= ST_CONFIRM;
            end
          end
          ST_CONFIRM: begin
            if (scan_single && (scan_code == cand_q)) begin
              match_q <= match_q + 1'b1;
            end else begin
              match_q <= '0;
              state_q <= ST_IDLE;
            end
          end
          ST_HELD: begin
            if (!scan_none) begin
              rel_q <= '0;
            end else if (rel_q == DB_LAST) begin
              rel_q      <= '0;
              key_held_q <= 1'b0;
              state_q    <= ST_IDLE;
            end else begin
              rel_q <= rel_q + 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign col_drive = col_drive_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign units     = units_q;
  assign tens      = tens_q;

endmodule
